parking_occupancy_ctrl: RTL and testbench

// - Central controller for the car-park sensor lanes. Collects inc/dec pulses from NUM_LANES

---
 rtl/parking_occupancy_ctrl.sv | 173 +++++++++++++++++
 tb/tb_parking_occupancy_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/parking_occupancy_ctrl.sv
// -----------------------------------------------------------------------------
// parking_occupancy_ctrl
//
// Purpose:
//   Central controller for the car-park sensor lanes. Merges the entry/exit
//   pulses of NUM_LANES direction detectors into a saturating occupancy count
//   with full/empty flags and sticky overflow/underflow errors. Also sequences
//   the lane-0 entry barrier. A request opens the barrier when space is free.
//   A confirmed lane-0 entry closes it. If no entry arrives in time, the lane-0
//   detector receives a resync pulse.
//
// Ports:
//   clk          in   1          system clock, rising edge
//   rst_n        in   1          asynchronous active-low reset
//   inc          in   NUM_LANES  1-cycle entry pulses, one bit per lane
//   dec          in   NUM_LANES  1-cycle exit pulses, one bit per lane
//   gate_req     in   1          ticket-button request (level or pulse)
//   err_clr      in   1          clears the sticky error flags
//   count        out  CNT_W      current occupancy
//   full         out  1          count == CAPACITY
//   empty        out  1          count == 0
//   gate_open    out  1          barrier drive, 1 = raised
//   det_clr      out  1          1-cycle resync pulse to the lane-0 detector
//   err_ovf      out  1          sticky: an increment was lost at CAPACITY
//   err_unf      out  1          sticky: a decrement was lost at 0
//   stat_entries out  16         wrapping total of inc pulses (0 if stats off)
//   stat_exits   out  16         wrapping total of dec pulses (0 if stats off)
//
// Configuration:
//   PARK_STATS_EN  when defined, stat_entries/stat_exits are live wrapping
//                  counters; otherwise both ports are tied to zero.
// -----------------------------------------------------------------------------
module parking_occupancy_ctrl #(
  parameter int NUM_LANES = 2,
  parameter int CAPACITY  = 100,
  parameter int CNT_W     = 8,
  parameter int TIMEOUT   = 1000,
  parameter int TMR_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_LANES-1:0] inc,
  input  logic [NUM_LANES-1:0] dec,
  input  logic                 gate_req,
  input  logic                 err_clr,
  output logic [CNT_W-1:0]     count,
  output logic                 full,
  output logic                 empty,
  output logic                 gate_open,
  output logic                 det_clr,
  output logic                 err_ovf,
  output logic                 err_unf,
  output logic [15:0]          stat_entries,
  output logic [15:0]          stat_exits
);

  // Two guard bits give headroom for the sign and for additions above CAPACITY.
  localparam int SW = CNT_W + 2;
  localparam logic signed [SW-1:0] CAP_S = SW'(CAPACITY);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    G_IDLE  = 4'b0001,
    G_OPEN  = 4'b0010,
    G_CLOSE = 4'b0100,
    G_TOUT  = 4'b1000
  } gate_state_t;

  logic [SW-1:0]        n_i;
  logic [SW-1:0]        n_d;
  logic signed [SW-1:0] sum;
  logic                 ovf;
  logic                 unf;
  logic [CNT_W-1:0]     count_nxt;

  gate_state_t          state;
  gate_state_t          state_nxt;
  logic [TMR_W-1:0]     timer;

  // Occupancy arithmetic
  always_comb begin
    n_i = '0;
    n_d = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      n_i = n_i + SW'(inc[l]);
      n_d = n_d + SW'(dec[l]);
    end
    sum = $signed({2'b00, count}) + $signed(n_i) - $signed(n_d);
    unf = sum[SW-1];
    ovf = !unf && (sum > CAP_S);
    if (ovf) begin
      count_nxt = CNT_W'(CAPACITY);
    end else if (unf) begin
      count_nxt = '0;
    end else begin
      count_nxt = sum[CNT_W-1:0];
    end
  end

  // full/empty are decoded from the value being loaded, so they line up
  // with count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count   <= '0;
      full    <= 1'b0;
      empty   <= 1'b1;
      err_ovf <= 1'b0;
      err_unf <= 1'b0;
    end else begin
      count   <= count_nxt;
      full    <= (count_nxt == CNT_W'(CAPACITY));
      empty   <= (count_nxt == '0);
      // A fresh error in the clearing cycle must survive the clear.
      err_ovf <= ovf | (err_ovf & ~err_clr);
      err_unf <= unf | (err_unf & ~err_clr);
    end
  end

  // Barrier next-state logic
  // Only inc[0] and gate_req steer the barrier. Other lanes and dec[0]
  // affect only the count.
  always_comb begin
    state_nxt = state;
    unique case (state)
      G_IDLE: begin
        if (gate_req && !full) state_nxt = G_OPEN;
      end
      G_OPEN: begin
        // When both happen in the same cycle, an entry takes priority over
        // the timeout.
        if (inc[0])                 state_nxt = G_CLOSE;
        else if (timer == TMR_LAST) state_nxt = G_TOUT;
      end
      G_CLOSE: state_nxt = G_IDLE;
      G_TOUT:  state_nxt = G_IDLE;
      default: state_nxt = G_IDLE;
    endcase
  end

  // The outputs are registered and decoded from the next state, so gate_open
  // and det_clr change on the same edge as the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= G_IDLE;
      timer     <= '0;
      gate_open <= 1'b0;
      det_clr   <= 1'b0;
    end else begin
      state     <= state_nxt;
      timer     <= (state == G_OPEN && state_nxt == G_OPEN) ? timer + 1'b1 : '0;
      gate_open <= (state_nxt == G_OPEN);
      det_clr   <= (state_nxt == G_TOUT);
    end
  end

`ifdef PARK_STATS_EN
  // These counters count raw pulses and wrap silently. They are
  // independent of occupancy saturation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_entries <= '0;
      stat_exits   <= '0;
    end else begin
      stat_entries <= stat_entries + 16'(n_i);
      stat_exits   <= stat_exits + 16'(n_d);
    end
  end
`else
  assign stat_entries = 16'd0;
  assign stat_exits   = 16'd0;
`endif

endmodule

// File: tb/tb_parking_occupancy_ctrl.sv
// -----------------------------------------------------------------------------
// tb_parking_occupancy_ctrl
//
// Purpose:
//   Directed testbench for parking_occupancy_ctrl. Two instances share
//   clk/rst_n:
//     dut_a  CAPACITY=100, TIMEOUT=1000 : counting, underflow, entry close,
//                                         asynchronous reset
//     dut_b  CAPACITY=4,   TIMEOUT=8    : overflow, full blocking, timeout
//   Expected values are hand-computed. Stats expectations come from a pulse
//   tally kept by the drive tasks. The tally is zero when PARK_STATS_EN is
//   undefined.
// -----------------------------------------------------------------------------
module tb_parking_occupancy_ctrl;

  logic       clk;
  logic       rst_n;

  logic [1:0] inc_a, dec_a, inc_b, dec_b;
  logic       req_a, clr_a, req_b, clr_b;
  logic [7:0] count_a, count_b;
  logic       full_a, empty_a, open_a, detclr_a, ovf_a, unf_a;
  logic       full_b, empty_b, open_b, detclr_b, ovf_b, unf_b;
  logic [15:0] ent_a, ext_a, ent_b, ext_b;

  logic [15:0] tally_ent_a, tally_ext_a, tally_ent_b, tally_ext_b;

  int checks;
  int errors;

  parking_occupancy_ctrl #(
    .NUM_LANES(2), .CAPACITY(100), .CNT_W(8), .TIMEOUT(1000), .TMR_W(16)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .inc(inc_a), .dec(dec_a),
    .gate_req(req_a), .err_clr(clr_a), .count(count_a), .full(full_a),
    .empty(empty_a), .gate_open(open_a), .det_clr(detclr_a),
    .err_ovf(ovf_a), .err_unf(unf_a),
    .stat_entries(ent_a), .stat_exits(ext_a)
  );

  parking_occupancy_ctrl #(
    .NUM_LANES(2), .CAPACITY(4), .CNT_W(8), .TIMEOUT(8), .TMR_W(16)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .inc(inc_b), .dec(dec_b),
    .gate_req(req_b), .err_clr(clr_b), .count(count_b), .full(full_b),
    .empty(empty_b), .gate_open(open_b), .det_clr(detclr_b),
    .err_ovf(ovf_b), .err_unf(unf_b),
    .stat_entries(ent_b), .stat_exits(ext_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs are applied at a negedge and held through one posedge. They are
  // then cleared at the following negedge, where outputs are sampled.
  task automatic drive_a(input logic [1:0] i, input logic [1:0] d,
                         input logic g, input logic c);
    inc_a = i; dec_a = d; req_a = g; clr_a = c;
    @(negedge clk);
`ifdef PARK_STATS_EN
    tally_ent_a = tally_ent_a + 16'($countones(i));
    tally_ext_a = tally_ext_a + 16'($countones(d));
`endif
    inc_a = '0; dec_a = '0; req_a = 1'b0; clr_a = 1'b0;
  endtask

  task automatic drive_b(input logic [1:0] i, input logic [1:0] d,
                         input logic g, input logic c);
    inc_b = i; dec_b = d; req_b = g; clr_b = c;
    @(negedge clk);
`ifdef PARK_STATS_EN
    tally_ent_b = tally_ent_b + 16'($countones(i));
    tally_ext_b = tally_ext_b + 16'($countones(d));
`endif
    inc_b = '0; dec_b = '0; req_b = 1'b0; clr_b = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    inc_a = '0; dec_a = '0; req_a = 1'b0; clr_a = 1'b0;
    inc_b = '0; dec_b = '0; req_b = 1'b0; clr_b = 1'b0;
    tally_ent_a = '0; tally_ext_a = '0; tally_ent_b = '0; tally_ext_b = '0;
    #12;
    checks++;
    if ({count_a, full_a, empty_a, open_a, detclr_a, ovf_a, unf_a} !== {8'd0, 6'b010000}) begin
      errors++;
      $display("[TB] FAIL reset_a: got count=%0d f=%b e=%b g=%b d=%b o=%b u=%b, want 0 0 1 0 0 0 0",
               count_a, full_a, empty_a, open_a, detclr_a, ovf_a, unf_a);
    end
    checks++;
    if ({count_b, full_b, empty_b, open_b, detclr_b, ovf_b, unf_b} !== {8'd0, 6'b010000}) begin
      errors++;
      $display("[TB] FAIL reset_b: got count=%0d f=%b e=%b g=%b d=%b o=%b u=%b, want 0 0 1 0 0 0 0",
               count_b, full_b, empty_b, open_b, detclr_b, ovf_b, unf_b);
    end
    checks++;
    if ({ent_a, ext_a, ent_b, ext_b} !== 64'd0) begin
      errors++;
      $display("[TB] FAIL reset_stats: got %0d %0d %0d %0d, want all 0", ent_a, ext_a, ent_b, ext_b);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_count_up();
    for (int k = 1; k <= 3; k++) begin
      drive_a(2'b01, 2'b00, 1'b0, 1'b0);
      checks++;
      if (count_a !== 8'(k) || empty_a !== 1'b0) begin
        errors++;
        $display("[TB] FAIL count_up_%0d: got count=%0d empty=%b, want %0d 0", k, count_a, empty_a, k);
      end
      idle(1);
    end
  endtask

  task automatic test_gate_entry();
    // count_a = 3
    drive_a(2'b00, 2'b00, 1'b1, 1'b0);
    checks++;
    if (open_a !== 1'b1) begin
      errors++; $display("[TB] FAIL gate_open_rise: got %b want 1", open_a);
    end
    for (int k = 0; k < 9; k++) begin
      idle(1);
      checks++;
      if (open_a !== 1'b1 || detclr_a !== 1'b0) begin
        errors++; $display("[TB] FAIL gate_hold_%0d: got open=%b det=%b want 1 0", k, open_a, detclr_a);
      end
    end
    drive_a(2'b01, 2'b00, 1'b0, 1'b0);
    checks++;
    if (open_a !== 1'b0 || count_a !== 8'd4) begin
      errors++; $display("[TB] FAIL gate_close: got open=%b count=%0d want 0 4", open_a, count_a);
    end
    // A request during the close cycle is not sampled.
    drive_a(2'b00, 2'b00, 1'b1, 1'b0);
    checks++;
    if (open_a !== 1'b0 || detclr_a !== 1'b0) begin
      errors++; $display("[TB] FAIL gate_close_ignore: got open=%b det=%b want 0 0", open_a, detclr_a);
    end
    drive_a(2'b00, 2'b00, 1'b1, 1'b0);
    checks++;
    if (open_a !== 1'b1) begin
      errors++; $display("[TB] FAIL gate_reopen: got %b want 1", open_a);
    end
    drive_a(2'b01, 2'b00, 1'b0, 1'b0);
    checks++;
    if (open_a !== 1'b0 || count_a !== 8'd5) begin
      errors++; $display("[TB] FAIL gate_reclose: got open=%b count=%0d want 0 5", open_a, count_a);
    end
    idle(1);
  endtask

  task automatic test_mixed();
    drive_a(2'b11, 2'b01, 1'b0, 1'b0);
    checks++;
    if (count_a !== 8'd6) begin
      errors++; $display("[TB] FAIL mixed_net: got %0d want 6", count_a);
    end
    // A same-lane inc and dec in one cycle cancel out.
    drive_a(2'b10, 2'b10, 1'b0, 1'b0);
    checks++;
    if (count_a !== 8'd6 || open_a !== 1'b0) begin
      errors++; $display("[TB] FAIL mixed_same_lane: got count=%0d open=%b want 6 0", count_a, open_a);
    end
  endtask

  task automatic test_underflow();
    drive_a(2'b00, 2'b11, 1'b0, 1'b0);
    drive_a(2'b00, 2'b11, 1'b0, 1'b0);
    drive_a(2'b00, 2'b11, 1'b0, 1'b0);
    checks++;
    if (count_a !== 8'd0 || empty_a !== 1'b1 || unf_a !== 1'b0) begin
      errors++; $display("[TB] FAIL drain: got count=%0d empty=%b unf=%b want 0 1 0", count_a, empty_a, unf_a);
    end
    drive_a(2'b00, 2'b11, 1'b0, 1'b0);
    checks++;
    if (count_a !== 8'd0 || unf_a !== 1'b1) begin
      errors++; $display("[TB] FAIL underflow: got count=%0d unf=%b want 0 1", count_a, unf_a);
    end
    drive_a(2'b00, 2'b01, 1'b0, 1'b1);
    checks++;
    if (unf_a !== 1'b1) begin
      errors++; $display("[TB] FAIL unf_clear_collide: got %b want 1", unf_a);
    end
    drive_a(2'b00, 2'b00, 1'b0, 1'b1);
    checks++;
    if (unf_a !== 1'b0 || count_a !== 8'd0) begin
      errors++; $display("[TB] FAIL unf_clear: got unf=%b count=%0d want 0 0", unf_a, count_a);
    end
  endtask

  task automatic test_overflow();
    drive_b(2'b11, 2'b00, 1'b0, 1'b0);
    drive_b(2'b11, 2'b00, 1'b0, 1'b0);
    checks++;
    if (count_b !== 8'd4 || full_b !== 1'b1 || ovf_b !== 1'b0) begin
      errors++; $display("[TB] FAIL fill: got count=%0d full=%b ovf=%b want 4 1 0", count_b, full_b, ovf_b);
    end
    drive_b(2'b01, 2'b00, 1'b0, 1'b0);
    checks++;
    if (count_b !== 8'd4 || ovf_b !== 1'b1 || full_b !== 1'b1) begin
      errors++; $display("[TB] FAIL overflow: got count=%0d ovf=%b full=%b want 4 1 1", count_b, ovf_b, full_b);
    end
    drive_b(2'b00, 2'b00, 1'b0, 1'b1);
    checks++;
    if (ovf_b !== 1'b0 || count_b !== 8'd4) begin
      errors++; $display("[TB] FAIL ovf_clear: got ovf=%b count=%0d want 0 4", ovf_b, count_b);
    end
    drive_b(2'b00, 2'b00, 1'b1, 1'b0);
    idle(2);
    checks++;
    if (open_b !== 1'b0) begin
      errors++; $display("[TB] FAIL req_when_full: got open=%b want 0", open_b);
    end
    drive_b(2'b00, 2'b11, 1'b0, 1'b0);
    drive_b(2'b00, 2'b11, 1'b0, 1'b0);
    checks++;
    if (count_b !== 8'd0 || empty_b !== 1'b1 || full_b !== 1'b0) begin
      errors++; $display("[TB] FAIL empty_b: got count=%0d empty=%b full=%b want 0 1 0", count_b, empty_b, full_b);
    end
  endtask

  task automatic test_timeout();
    drive_b(2'b00, 2'b00, 1'b1, 1'b0);
    checks++;
    if (open_b !== 1'b1 || detclr_b !== 1'b0) begin
      errors++; $display("[TB] FAIL tout_open_0: got open=%b det=%b want 1 0", open_b, detclr_b);
    end
    for (int k = 1; k < 8; k++) begin
      idle(1);
      checks++;
      if (open_b !== 1'b1 || detclr_b !== 1'b0) begin
        errors++; $display("[TB] FAIL tout_open_%0d: got open=%b det=%b want 1 0", k, open_b, detclr_b);
      end
    end
    idle(1);
    checks++;
    if (open_b !== 1'b0 || detclr_b !== 1'b1) begin
      errors++; $display("[TB] FAIL tout_detclr: got open=%b det=%b want 0 1", open_b, detclr_b);
    end
    idle(1);
    checks++;
    if (open_b !== 1'b0 || detclr_b !== 1'b0) begin
      errors++; $display("[TB] FAIL tout_end: got open=%b det=%b want 0 0", open_b, detclr_b);
    end
  endtask

  task automatic test_entry_vs_timeout();
    drive_b(2'b00, 2'b00, 1'b1, 1'b0);
    idle(7);
    drive_b(2'b01, 2'b00, 1'b0, 1'b0);
    checks++;
    if (open_b !== 1'b0 || detclr_b !== 1'b0 || count_b !== 8'd1) begin
      errors++; $display("[TB] FAIL entry_wins: got open=%b det=%b count=%0d want 0 0 1", open_b, detclr_b, count_b);
    end
    idle(1);
    checks++;
    if (detclr_b !== 1'b0) begin
      errors++; $display("[TB] FAIL entry_wins_after: got det=%b want 0", detclr_b);
    end
  endtask

  task automatic test_full_block();
    drive_b(2'b11, 2'b00, 1'b0, 1'b0);
    // Reaching CAPACITY with a request in the same cycle still grants it.
    drive_b(2'b01, 2'b00, 1'b1, 1'b0);
    checks++;
    if (count_b !== 8'd4 || full_b !== 1'b1 || open_b !== 1'b1) begin
      errors++; $display("[TB] FAIL full_same_cycle: got count=%0d full=%b open=%b want 4 1 1", count_b, full_b, open_b);
    end
    drive_b(2'b01, 2'b00, 1'b0, 1'b0);
    checks++;
    if (count_b !== 8'd4 || ovf_b !== 1'b1 || open_b !== 1'b0) begin
      errors++; $display("[TB] FAIL full_entry: got count=%0d ovf=%b open=%b want 4 1 0", count_b, ovf_b, open_b);
    end
    idle(1);
    drive_b(2'b00, 2'b00, 1'b1, 1'b1);
    checks++;
    if (open_b !== 1'b0 || ovf_b !== 1'b0) begin
      errors++; $display("[TB] FAIL full_blocks: got open=%b ovf=%b want 0 0", open_b, ovf_b);
    end
  endtask

  task automatic test_async_reset();
    drive_a(2'b10, 2'b00, 1'b0, 1'b0);
    checks++;
    if (count_a !== 8'd1 || open_a !== 1'b0) begin
      errors++; $display("[TB] FAIL lane1_no_fsm: got count=%0d open=%b want 1 0", count_a, open_a);
    end
    drive_a(2'b00, 2'b00, 1'b1, 1'b0);
    checks++;
    if (open_a !== 1'b1) begin
      errors++; $display("[TB] FAIL pre_reset_open: got %b want 1", open_a);
    end
    checks++;
    if (ent_a !== tally_ent_a || ext_a !== tally_ext_a) begin
      errors++; $display("[TB] FAIL stats_a: got %0d/%0d want %0d/%0d", ent_a, ext_a, tally_ent_a, tally_ext_a);
    end
    checks++;
    if (ent_b !== tally_ent_b || ext_b !== tally_ext_b) begin
      errors++; $display("[TB] FAIL stats_b: got %0d/%0d want %0d/%0d", ent_b, ext_b, tally_ent_b, tally_ext_b);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (open_a !== 1'b0 || count_a !== 8'd0 || count_b !== 8'd0 || empty_a !== 1'b1) begin
      errors++; $display("[TB] FAIL async_reset: got open=%b count_a=%0d count_b=%0d empty=%b want 0 0 0 1",
                         open_a, count_a, count_b, empty_a);
    end
    checks++;
    if ({ent_a, ext_a, ent_b, ext_b} !== 64'd0) begin
      errors++; $display("[TB] FAIL async_reset_stats: got %0d %0d %0d %0d want all 0", ent_a, ext_a, ent_b, ext_b);
    end
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_count_up();
    test_gate_entry();
    test_mixed();
    test_underflow();
    test_overflow();
    test_timeout();
    test_entry_vs_timeout();
    test_full_block();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
